// File: rtl/imem_arb_pkg.sv
// Shared types and address-classification helpers for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic is_oor(input logic [31:0] addr, input int unsigned depth);
    return {2'b00, addr[31:2]} >= depth;
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates fetch vs debug onto a single-ported imem; responses 1 cycle after accept.
// Ready is the combinational grant (fetch priority, debug forced after STARVE_MAX losses); responses have no backpressure.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned STARVE_MAX  = 8,
  parameter logic [31:0] NOP_INST    = imem_arb_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req_valid,
  output logic        fetch_req_ready,
  input  logic [31:0] fetch_addr,
  output logic        fetch_rsp_valid,
  output logic [31:0] fetch_rsp_data,
  output logic        fetch_rsp_err,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  owner_e           rsp_owner;
  logic             rsp_bypass;
  logic [31:0]      rsp_bypass_data;
  logic             rsp_err;

  logic        dbg_force;
  logic        fetch_gnt;
  logic        dbg_gnt;
  logic        f_mis;
  logic        f_ok;
  logic        d_ok;
  logic [31:0] rsp_dat;

  // All grants are qualified by rst_n so every output is quiet while reset is held.
  always_comb begin
    dbg_force = dbg_req_valid && (starve_cnt == CNT_W'(STARVE_MAX));
    fetch_gnt = rst_n && fetch_req_valid && !dbg_force;
    dbg_gnt   = rst_n && dbg_req_valid && !fetch_gnt;
    f_mis     = is_misaligned(fetch_addr);
    f_ok      = !f_mis && !is_oor(fetch_addr, DEPTH_WORDS);
    d_ok      = !is_misaligned(dbg_addr) && !is_oor(dbg_addr, DEPTH_WORDS);
  end

  assign fetch_req_ready = fetch_gnt;
  assign dbg_req_ready   = dbg_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt && f_ok) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[31:2];
    end else if (dbg_gnt && d_ok) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr[31:2];
      mem_wdata = dbg_we ? dbg_wdata : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt      <= '0;
      rsp_owner       <= OWN_NONE;
      rsp_bypass      <= 1'b0;
      rsp_bypass_data <= '0;
      rsp_err         <= 1'b0;
    end else begin
      if (!dbg_req_valid || dbg_gnt) begin
        starve_cnt <= '0;
      end else if (fetch_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      rsp_owner       <= OWN_NONE;
      rsp_bypass      <= 1'b0;
      rsp_bypass_data <= '0;
      rsp_err         <= 1'b0;
      if (fetch_gnt) begin
        rsp_owner       <= OWN_FETCH;
        rsp_bypass      <= !f_ok;
        rsp_bypass_data <= f_ok ? 32'h0 : NOP_INST;
        rsp_err         <= f_mis;
      end else if (dbg_gnt) begin
        // Only a legal debug read takes its data from memory; writes and filtered reads return 0.
        rsp_owner  <= OWN_DBG;
        rsp_bypass <= !(d_ok && !dbg_we);
      end
    end
  end

  assign rsp_dat         = rsp_bypass ? rsp_bypass_data : mem_rdata;
  assign fetch_rsp_valid = rst_n && (rsp_owner == OWN_FETCH);
  assign fetch_rsp_data  = fetch_rsp_valid ? rsp_dat : 32'h0;
  assign fetch_rsp_err   = fetch_rsp_valid && rsp_err;
  assign dbg_rsp_valid   = rst_n && (rsp_owner == OWN_DBG);
  assign dbg_rsp_data    = dbg_rsp_valid ? rsp_dat : 32'h0;

endmodule
